keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner, successor to the fixed 4x4 poller. Drives one-hot column strobes, debounces row returns, and reports a linear key code with one-cycle press and release strobes. Adds multi-key rejection, a scan enable and optional auto-repeat. Sits between keypad pads (after 2-FF row synchronisers) and the key-event consumer.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_row_encoder.sv | 37 +++
 rtl/keypad_scanner.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
//   state_t          : scanner FSM states
//   NO_KEY           : "nothing latched" row pattern
//   is_onehot()      : true when exactly one bit of an 8-bit vector is set
//   onehot_to_index(): bit position of the single set bit (no priority logic)
//   sat_inc()        : 16-bit saturating increment used by every counter
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DEBOUNCE,
    ST_PRESSED
  } state_t;

  localparam int CNT_W     = 16;
  localparam int ROW_IDX_W = 3;   // enough for up to 8 rows or columns
  localparam int MAX_LINES = 8;

  localparam logic [MAX_LINES-1:0] NO_KEY = '0;

  function automatic logic is_onehot(input logic [MAX_LINES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // OR together the indices of all set bits; correct only for one-hot input,
  // which is all the scanner ever feeds it.
  function automatic logic [ROW_IDX_W-1:0] onehot_to_index(input logic [MAX_LINES-1:0] v);
    logic [ROW_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (v[i]) idx = idx | ROW_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/keypad_row_encoder.sv
// Combinational classifier for the synchronised row returns.
//   row_in : row returns, active high
//   zero   : no row active
//   onehot : exactly one row active
//   multi  : more than one row active
//   index  : position of the active row (valid only when onehot)
module keypad_row_encoder
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS = 4
) (
  input  logic [NUM_ROWS-1:0]  row_in,
  output logic                 zero,
  output logic                 onehot,
  output logic                 multi,
  output logic [ROW_IDX_W-1:0] index
);

  logic [MAX_LINES-1:0] row_pad;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LINES; gi++) begin : g_pad
      if (gi < NUM_ROWS) begin : g_live
        assign row_pad[gi] = row_in[gi];
      end else begin : g_tie
        assign row_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign zero   = (row_pad == '0);
  assign onehot = is_onehot(row_pad);
  assign multi  = !zero && !onehot;
  assign index  = onehot_to_index(row_pad);

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix keypad scanner.
// Strobes one column at a time, lets it settle, samples the rows, debounces a
// single-key press, and reports a linear key code with press / repeat /
// release strobes. Multi-row hits in one column are rejected and flagged.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   scan_en        : allow scanning (checked when leaving IDLE and at wrap)
//   repeat_en      : enable auto-repeat while a key is held
//   keypad_row_in  : synchronised row returns, active high
//   keypad_col_out : one-hot column drive, all zero when idle
//   key_code       : row*NUM_COLS + col of the last accepted key
//   key_valid      : one-cycle strobe on press and on each auto-repeat
//   key_held       : level, key debounced down
//   key_release    : one-cycle strobe on accepted release
//   multi_key      : one-cycle strobe, several rows active in sampled column
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SETTLE_TICKS   = 20,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 200,
  parameter int REPEAT_PERIOD  = 50,
  parameter int CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_en,
  input  logic                repeat_en,
  input  logic [NUM_ROWS-1:0] keypad_row_in,
  output logic [NUM_COLS-1:0] keypad_col_out,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release,
  output logic                multi_key
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t                state_reg, state_next;
  logic [NUM_COLS-1:0]   col_reg, col_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CNT_W-1:0]      rel_cnt_reg, rel_cnt_next;
  logic [CNT_W-1:0]      rep_cnt_reg, rep_cnt_next;
  logic                  rep_phase_reg, rep_phase_next;  // 0: waiting for first repeat
  logic [NUM_ROWS-1:0]   latch_reg, latch_next;
  logic [ROW_IDX_W-1:0]  row_idx_reg, row_idx_next;
  logic [CODE_W-1:0]     code_reg, code_next;
  logic                  valid_reg, valid_next;
  logic                  held_reg, held_next;
  logic                  release_reg, release_next;
  logic                  multi_reg, multi_next;

  logic                  enc_zero, enc_onehot, enc_multi;
  logic [ROW_IDX_W-1:0]  enc_index;

  keypad_row_encoder #(
    .NUM_ROWS (NUM_ROWS)
  ) u_enc (
    .row_in (keypad_row_in),
    .zero   (enc_zero),
    .onehot (enc_onehot),
    .multi  (enc_multi),
    .index  (enc_index)
  );

  // Column advance: rotate left; at the wrap point a dropped scan_en parks
  // the scanner in IDLE with all columns off.
  logic                 adv_stop;
  state_t               adv_state;
  logic [NUM_COLS-1:0]  adv_col;
  logic [ROW_IDX_W-1:0] col_idx;
  logic [CODE_W-1:0]    press_code;
  logic                 row_match;

  assign adv_stop   = col_reg[NUM_COLS-1] && !scan_en;
  assign adv_state  = adv_stop ? ST_IDLE : ST_SETTLE;
  assign adv_col    = adv_stop ? '0 : {col_reg[NUM_COLS-2:0], col_reg[NUM_COLS-1]};
  assign col_idx    = onehot_to_index(MAX_LINES'(col_reg));
  assign press_code = CODE_W'(int'(row_idx_reg) * NUM_COLS + int'(col_idx));
  // Latched pattern is always one-hot, so a match also implies onehot.
  assign row_match  = enc_onehot && (keypad_row_in == latch_reg);

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    cnt_next       = cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_phase_next = rep_phase_reg;
    latch_next     = latch_reg;
    row_idx_next   = row_idx_reg;
    code_next      = code_reg;
    held_next      = held_reg;
    valid_next     = 1'b0;
    release_next   = 1'b0;
    multi_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        col_next = '0;
        if (scan_en) begin
          col_next   = NUM_COLS'(1);
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end

      ST_SAMPLE: begin
        multi_next = enc_multi;
        cnt_next   = '0;
        if (enc_zero || enc_multi) begin
          col_next   = adv_col;
          state_next = adv_state;
        end else begin
          latch_next   = keypad_row_in;
          row_idx_next = enc_index;
          state_next   = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (row_match) begin
          if (cnt_reg == DEB_LAST) begin
            cnt_next       = '0;
            rel_cnt_next   = '0;
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
            valid_next     = 1'b1;
            held_next      = 1'b1;
            code_next      = press_code;
            state_next     = ST_PRESSED;
          end else begin
            cnt_next = sat_inc(cnt_reg);
          end
        end else begin
          cnt_next   = '0;
          col_next   = adv_col;
          state_next = adv_state;
        end
      end

      ST_PRESSED: begin
        if (row_match) begin
          rel_cnt_next = '0;
          if (repeat_en) begin
            if (rep_cnt_reg == (rep_phase_reg ? PERIOD_LAST : DELAY_LAST)) begin
              valid_next     = 1'b1;
              rep_cnt_next   = '0;
              rep_phase_next = 1'b1;
            end else begin
              rep_cnt_next = sat_inc(rep_cnt_reg);
            end
          end else begin
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
          end
        end else begin
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
          if (rel_cnt_reg == DEB_LAST) begin
            rel_cnt_next = '0;
            release_next = 1'b1;
            held_next    = 1'b0;
            cnt_next     = '0;
            col_next     = adv_col;
            state_next   = adv_state;
          end else begin
            rel_cnt_next = sat_inc(rel_cnt_reg);
          end
        end
      end

      default: begin
        col_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      col_reg       <= '0;
      cnt_reg       <= '0;
      rel_cnt_reg   <= '0;
      rep_cnt_reg   <= '0;
      rep_phase_reg <= 1'b0;
      latch_reg     <= NUM_ROWS'(NO_KEY);
      row_idx_reg   <= '0;
      code_reg      <= '0;
      valid_reg     <= 1'b0;
      held_reg      <= 1'b0;
      release_reg   <= 1'b0;
      multi_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      cnt_reg       <= cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      rep_phase_reg <= rep_phase_next;
      latch_reg     <= latch_next;
      row_idx_reg   <= row_idx_next;
      code_reg      <= code_next;
      valid_reg     <= valid_next;
      held_reg      <= held_next;
      release_reg   <= release_next;
      multi_reg     <= multi_next;
    end
  end

  assign keypad_col_out = col_reg;
  assign key_code       = code_reg;
  assign key_valid      = valid_reg;
  assign key_held       = held_reg;
  assign key_release    = release_reg;
  assign multi_key      = multi_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected events,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_keypad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters (4x4)
  logic        rst_n, scan_en, repeat_en;
  logic [3:0]  row_in, col_out, code;
  logic        valid, held, rel, multi;
  logic [15:0] keys;

  // Sweep instance (3 rows, 5 columns, short timing)
  logic        scan_en2, repeat_en2;
  logic [2:0]  row2;
  logic [4:0]  col2;
  logic [3:0]  code2;
  logic        valid2, held2, rel2, multi2;
  logic [14:0] keys2;

  keypad_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .repeat_en(repeat_en),
    .keypad_row_in(row_in), .keypad_col_out(col_out), .key_code(code),
    .key_valid(valid), .key_held(held), .key_release(rel), .multi_key(multi)
  );

  keypad_scanner #(
    .NUM_ROWS(3), .NUM_COLS(5), .SETTLE_TICKS(3), .DEBOUNCE_TICKS(2)
  ) u_sw (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en2), .repeat_en(repeat_en2),
    .keypad_row_in(row2), .keypad_col_out(col2), .key_code(code2),
    .key_valid(valid2), .key_held(held2), .key_release(rel2), .multi_key(multi2)
  );

  // Keypad models: a pressed key connects its column drive to its row.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_out[c]) row_in[r] = 1'b1;
  end

  always_comb begin
    row2 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (keys2[r*5+c] && col2[c]) row2[r] = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard. kind: 0 key_valid, 1 key_release, 2 multi_key.
  // rel >= 0: required cycles since the last press strobe.
  typedef struct {
    int kind;
    int code;
    int held;
    int rel;
  } ev_t;

  ev_t exp_q[$];
  int  press_cyc = 0;
  ev_t m_e;
  int  m_kind;

  task automatic push_ev(input int k, input int c, input int h, input int r);
    ev_t e;
    e.kind = k; e.code = c; e.held = h; e.rel = r;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid || rel || multi)) begin
      m_kind = valid ? 0 : (rel ? 1 : 2);
      check("strobe_exclusive", 32'(valid) + 32'(rel) + 32'(multi), 1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got kind %0d code %0d at cycle %0d, expected no event",
                 m_kind, code, cyc);
      end else begin
        m_e = exp_q.pop_front();
        check("ev_kind", m_kind, m_e.kind);
        check("ev_code", 32'(code), m_e.code);
        check("ev_held", 32'(held), m_e.held);
        if (m_e.rel > 0) check("ev_spacing", cyc - press_cyc, m_e.rel);
        if (m_kind == 0 && m_e.rel == 0) press_cyc = cyc;
        $display("event kind=%0d code=%0d held=%0d cycle=%0d", m_kind, code, held, cyc);
      end
    end
  end

  function automatic bit probe(input int which, input int val);
    case (which)
      0: return valid;
      1: return rel;
      2: return multi;
      3: return 32'(col_out) == val;
      4: return 32'(col2) == val;
      5: return valid2;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) for the next negedge where the condition holds.
  task automatic wait_for(input int which, input int val, input int limit,
                          input string name, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!probe(which, val) && waited < limit);
    n_cmp++;
    if (!probe(which, val)) begin
      n_bad++;
      $display("FAIL %s: timed out after %0d cycles, expected condition", name, limit);
    end
  endtask

  int w;
  int seq[6] = '{1, 2, 4, 8, 16, 1};

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; repeat_en = 1'b0; keys = '0;
    scan_en2 = 1'b0; repeat_en2 = 1'b0; keys2 = '0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col_out), 0);
    check("rst_code", 32'(code), 0);
    check("rst_held", 32'(held), 0);
    check("rst_strobes", {valid, rel, multi}, 0);
    rst_n = 1'b1;

    // Key down but scanning disabled: columns stay off
    keys[6] = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_col_off", 32'(col_out), 0);
    check("idle_no_held", 32'(held), 0);

    // Single press row1/col2 -> code 6
    push_ev(0, 6, 1, 0);
    scan_en = 1'b1;
    wait_for(0, 0, 300, "press_valid", w);
    check("press_latency", w, 68);
    @(negedge clk);
    check("press_pulse_width", 32'(valid), 0);
    check("press_held", 32'(held), 1);
    check("press_col", 32'(col_out), 4);
    push_ev(1, 6, 0, -1);
    keys = '0;
    wait_for(1, 0, 50, "release_strobe", w);
    check("release_latency", w, 4);
    check("release_held", 32'(held), 0);
    check("resume_col", 32'(col_out), 8);

    // Bounce 1,0,1 around SAMPLE of column 2: no press
    wait_for(3, 4, 300, "bounce_col2", w);
    keys[6] = 1'b1;
    repeat (21) @(negedge clk);
    keys = '0;
    @(negedge clk);
    keys[6] = 1'b1;
    check("bounce_col_adv", 32'(col_out), 8);
    check("bounce_held", 32'(held), 0);
    @(negedge clk);
    keys = '0;

    // Multi-key: rows 0 and 2 in column 0
    keys[0] = 1'b1; keys[8] = 1'b1;
    push_ev(2, 6, 0, -1);
    wait_for(2, 0, 300, "multi_strobe", w);
    keys = '0;
    check("multi_next_col", 32'(col_out), 2);
    check("multi_held", 32'(held), 0);

    // Auto-repeat on: press, +200, +250, +300, +350
    repeat_en = 1'b1;
    push_ev(0, 6, 1, 0);
    push_ev(0, 6, 1, 200);
    push_ev(0, 6, 1, 250);
    push_ev(0, 6, 1, 300);
    push_ev(0, 6, 1, 350);
    keys[6] = 1'b1;
    wait_for(0, 0, 300, "rep_press", w);
    repeat (100) @(negedge clk);
    check("rep_held", 32'(held), 1);
    repeat (280) @(negedge clk);
    push_ev(1, 6, 0, -1);
    keys = '0;
    wait_for(1, 0, 50, "rep_release", w);

    // Auto-repeat off: exactly one strobe
    repeat_en = 1'b0;
    push_ev(0, 6, 1, 0);
    keys[6] = 1'b1;
    wait_for(0, 0, 300, "norep_press", w);
    repeat (380) @(negedge clk);
    push_ev(1, 6, 0, -1);
    keys = '0;
    wait_for(1, 0, 50, "norep_release", w);

    // Asynchronous reset while PRESSED
    push_ev(0, 6, 1, 0);
    keys[6] = 1'b1;
    wait_for(0, 0, 300, "pre_reset_press", w);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset_col", 32'(col_out), 0);
    check("areset_code", 32'(code), 0);
    check("areset_held", 32'(held), 0);
    check("areset_strobes", {valid, rel, multi}, 0);
    keys = '0;
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 3x5 sweep: column sequence with SETTLE_TICKS+1 cycles per column
    scan_en2 = 1'b1;
    wait_for(4, 1, 20, "sw_start", w);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("sw_col%0d", i), 32'(col2), seq[i]);
      repeat (4) @(negedge clk);
    end
    keys2[2*5+4] = 1'b1;
    wait_for(5, 0, 100, "sw_press", w);
    check("sw_code", 32'(code2), 14);
    check("sw_held", 32'(held2), 1);
    keys2 = '0;
    scan_en2 = 1'b0;
    repeat (10) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
